data_lsu: RTL and testbench
===========================

DATA_LSU -- requirements
Module: data_lsu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
REQ-002 The processor-side request ports SHALL be:
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_we  input  1  1=store, 0=load
- req_size  input  2  00=byte, 01=halfword, 10=word, 11=word
- req_unsigned  input  1  zero-extend sub-word loads
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
REQ-003 The processor-side response ports SHALL be:
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  load result
- resp_err  output  1  request rejected
REQ-004 The memory-side ports SHALL be:
- data_addr  output  32  byte address
- data_wr  output  1  write strobe; the memory writes on the clk rising edge
- data_out  output  32  write word
- data_in  input  32  combinational read of bytes [addr..addr+3], big-endian (MSB = byte at addr)

Function
REQ-005 The state machine SHALL have the states IDLE, READ, WRITE and RESP.
REQ-006 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid&&req_ready; addr, we, size, unsigned and wdata are captured at acceptance.
REQ-007 Transitions out of IDLE on acceptance SHALL be: load -> READ; word store -> WRITE; byte/halfword store -> READ.
REQ-008 In READ, the block SHALL drive data_addr=addr with data_wr=0 and register data_in at the clock edge; next state is RESP for a load and WRITE for a sub-word store.
REQ-009 In WRITE, the block SHALL drive data_addr=addr and data_wr=1 for exactly one cycle; next state is RESP.
REQ-010 data_out for stores SHALL be:
- word: wdata
- halfword: {wdata[15:0], old[15:0]}
- byte: {wdata[7:0], old[23:0]}
- old = word captured in READ (read-modify-write).
REQ-011 Load result SHALL be:
- word: data_in
- halfword: data_in[31:16]
- byte: data_in[31:24]
- halfword/byte are sign-extended, or zero-extended when unsigned=1.
REQ-012 In RESP, resp_valid SHALL be 1 for one cycle; resp_rdata holds the load result (0 for stores); next state is IDLE.
REQ-013 Latency from the acceptance edge to resp_valid SHALL be: load 2 cycles; word store 2 cycles; sub-word store 3 cycles.
REQ-014 Outside READ/WRITE, data_addr, data_out and data_wr SHALL be 0.
REQ-015 resp_rdata and resp_err SHALL hold their values until the next RESP.
REQ-016 req_valid deasserted in IDLE SHALL cause no state change and no memory access.

Reset
REQ-017 While rst=1 at a rising edge, the state SHALL become IDLE and all registers 0. The resulting outputs are req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, data_wr=0, data_addr=0, data_out=0.
REQ-018 data_wr SHALL be gated by !rst, so that reset asserted during WRITE suppresses that write.
REQ-019 An in-flight request SHALL be discarded on reset with no response.

Configuration
REQ-020 Macro LSU_MISALIGN_TRAP_EN controls alignment checking.
REQ-021 With LSU_MISALIGN_TRAP_EN defined, a misaligned request SHALL go directly IDLE -> RESP with resp_err=1, resp_rdata=0 and no memory access. Misaligned means:
- word with addr[1:0]!=0, or
- halfword with addr[0]!=0.
REQ-022 Without LSU_MISALIGN_TRAP_EN, resp_err SHALL be tied to 0 and every address SHALL be accessed as given.

Verification
REQ-023 Word store: addr=0x10, wdata=0xDEADBEEF -> data_wr=1 one cycle later with data_addr=0x10, data_out=0xDEADBEEF; resp_valid 2 cycles after acceptance.
REQ-024 Loads, with memory[0x10..0x13]=DE AD BE EF:
- LB signed at 0x10 -> 0xFFFFFFDE
- LBU -> 0x000000DE
- LH at 0x12 -> 0xFFFFBEEF
- LW at 0x10 -> 0xDEADBEEF
REQ-025 SB at 0x11, wdata=0x00000055, memory as REQ-024 -> write data_addr=0x11, data_out=0x55BEEF00 (with memory[0x14]=00); resp_valid 3 cycles after acceptance.
REQ-026 rst=1 in the WRITE cycle of a word store to 0x20 -> memory unchanged, no resp_valid, req_ready=1 next cycle.
REQ-027 LSU_MISALIGN_TRAP_EN defined, LW at 0x13 -> resp_err=1, resp_rdata=0 one cycle after acceptance, data_addr stays 0.
REQ-028 Back-to-back req_valid held high -> the second request is accepted only after RESP, with req_ready=0 in READ, WRITE and RESP.

Source files
------------

// File: rtl/data_lsu.sv
// ---------------------------------------------------------------------------
// data_lsu -- load/store unit between a processor request port and a simple
// byte-addressed memory with a combinational 32-bit big-endian read port.
//
// Loads read one word and extract/extend the byte, halfword or word at the
// address (the byte at the address is the MSB of data_in). Word stores write
// directly. Byte and halfword stores do a read-modify-write: the word at the
// address is read first and the new bytes replace its top lane(s).
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_*          processor request (valid/ready handshake, we, size,
//                  unsigned, addr, wdata)
//   resp_valid     one-cycle completion pulse
//   resp_rdata     load result (0 for stores), held until the next response
//   resp_err       misaligned-request flag, held until the next response
//   data_addr      memory byte address (0 when no access)
//   data_wr        memory write strobe (memory writes on rising clk)
//   data_out       memory write word (0 when not writing)
//   data_in        memory combinational read word
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned halfword/word requests are answered at once with
//                resp_err=1 and never touch memory
//   undefined -> every address is accessed as given, resp_err stays 0
// ---------------------------------------------------------------------------
module data_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] data_addr,
    output logic        data_wr,
    output logic [31:0] data_out,
    input  logic [31:0] data_in
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] old_reg;
    logic [31:0] rdata_reg;
    logic [1:0]  size_reg;
    logic        we_reg;
    logic        unsigned_reg;
    logic        err_reg;

    logic        misaligned;
    logic [31:0] load_result;
    logic [31:0] store_aligned;
    logic [3:0]  lane_mask;
    logic [31:0] merged_word;

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            default: misaligned = (req_addr[1:0] != 2'b00);
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // Extraction from the live read word; the addressed byte sits in [31:24].
    always_comb begin
        case (size_reg)
            2'b00:   load_result = {{24{~unsigned_reg & data_in[31]}}, data_in[31:24]};
            2'b01:   load_result = {{16{~unsigned_reg & data_in[31]}}, data_in[31:16]};
            default: load_result = data_in;
        endcase
    end

    // New data moved to the top lane(s); lane_mask marks which lanes it owns.
    always_comb begin
        case (size_reg)
            2'b00: begin
                store_aligned = {wdata_reg[7:0], 24'h000000};
                lane_mask     = 4'b1000;
            end
            2'b01: begin
                store_aligned = {wdata_reg[15:0], 16'h0000};
                lane_mask     = 4'b1100;
            end
            default: begin
                store_aligned = wdata_reg;
                lane_mask     = 4'b1111;
            end
        endcase
    end

    // Per-lane merge of new bytes over the word captured in READ.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[8*gi +: 8] = lane_mask[gi] ? store_aligned[8*gi +: 8]
                                                          : old_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            addr_reg     <= 32'h0;
            wdata_reg    <= 32'h0;
            old_reg      <= 32'h0;
            rdata_reg    <= 32'h0;
            size_reg     <= 2'b00;
            we_reg       <= 1'b0;
            unsigned_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg     <= req_addr;
                        wdata_reg    <= req_wdata;
                        size_reg     <= req_size;
                        we_reg       <= req_we;
                        unsigned_reg <= req_unsigned;
                        if (misaligned) begin
                            // Trap: skip memory entirely and answer next cycle.
                            rdata_reg <= 32'h0;
                            err_reg   <= 1'b1;
                            state_reg <= RESP;
                        end else if (req_we && req_size[1]) begin
                            state_reg <= WRITE;
                        end else begin
                            state_reg <= READ;
                        end
                    end
                end
                READ: begin
                    old_reg <= data_in;
                    if (!we_reg) begin
                        rdata_reg <= load_result;
                        err_reg   <= 1'b0;
                        state_reg <= RESP;
                    end else begin
                        state_reg <= WRITE;
                    end
                end
                WRITE: begin
                    rdata_reg <= 32'h0;
                    err_reg   <= 1'b0;
                    state_reg <= RESP;
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;
    assign data_addr  = (state_reg == READ || state_reg == WRITE) ? addr_reg : 32'h0;
    // Gated by rst so a reset landing on the WRITE cycle cancels the write.
    assign data_wr    = (state_reg == WRITE) && !rst;
    assign data_out   = (state_reg == WRITE) ? merged_word : 32'h0;

endmodule

// File: tb/tb_data_lsu.sv
// ---------------------------------------------------------------------------
// tb_data_lsu -- self-checking bench for data_lsu.
// A byte-array memory is attached to the memory port. A transaction-level
// model (reference byte memory + per-request expected cycle schedule) is
// checked against the DUT outputs on every falling edge; literal values pin
// the model on the key directed cases.
// ---------------------------------------------------------------------------
module tb_data_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] data_addr;
    logic        data_wr;
    logic [31:0] data_out;
    logic [31:0] data_in;

    data_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .data_addr    (data_addr),
        .data_wr      (data_wr),
        .data_out     (data_out),
        .data_in      (data_in)
    );

    always #5 clk = ~clk;

    // Environment memory: combinational big-endian read, write on rising edge.
    logic [7:0] mem [0:255];
    logic [7:0] ref_mem [0:255];

    always_comb begin
        data_in = {mem[data_addr[7:0]], mem[data_addr[7:0] + 8'd1],
                   mem[data_addr[7:0] + 8'd2], mem[data_addr[7:0] + 8'd3]};
    end

    always @(posedge clk) begin
        if (data_wr === 1'b1) begin
            mem[data_addr[7:0]]        <= data_out[31:24];
            mem[data_addr[7:0] + 8'd1] <= data_out[23:16];
            mem[data_addr[7:0] + 8'd2] <= data_out[15:8];
            mem[data_addr[7:0] + 8'd3] <= data_out[7:0];
        end
    end

    typedef struct {
        logic        ready;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] dout;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur_e;
    logic [31:0] m_rdata;
    logic        m_err;
    logic        chk_en;
    int          n_checks;
    int          n_fail;
    int          obs_cnt;
    logic [31:0] obs_addr;
    logic [31:0] obs_data;

    function automatic exp_t mk(input logic ready, input logic wr, input logic [31:0] addr,
                                input logic [31:0] dout, input logic rv,
                                input logic [31:0] rdata, input logic err);
        exp_t e;
        e.ready = ready; e.wr = wr; e.addr = addr; e.dout = dout;
        e.rv = rv; e.rdata = rdata; e.err = err;
        return e;
    endfunction

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        return {ref_mem[a], ref_mem[a + 8'd1], ref_mem[a + 8'd2], ref_mem[a + 8'd3]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected behaviour of one accepted request, pushed as a cycle schedule
    // starting with the cycle right after the acceptance edge.
    task automatic model_accept(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
        int          nbytes;
        logic        mis;
        logic [31:0] old;
        logic [31:0] res;
        logic [7:0]  ak;
        nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (nbytes == 2 && addr[0]) || (nbytes == 4 && addr[1:0] != 2'b00);
`endif
        if (mis) begin
            exp_q.push_back(mk(0, 0, 32'h0, 32'h0, 1, 32'h0, 1));
            m_rdata = 32'h0;
            m_err   = 1'b1;
        end else if (!we) begin
            old = ref_word(addr[7:0]);
            if (nbytes == 1)      res = {{24{~uns & old[31]}}, old[31:24]};
            else if (nbytes == 2) res = {{16{~uns & old[31]}}, old[31:16]};
            else                  res = old;
            exp_q.push_back(mk(0, 0, addr, 32'h0, 0, m_rdata, m_err));
            exp_q.push_back(mk(0, 0, 32'h0, 32'h0, 1, res, 0));
            m_rdata = res;
            m_err   = 1'b0;
        end else begin
            if (nbytes != 4) exp_q.push_back(mk(0, 0, addr, 32'h0, 0, m_rdata, m_err));
            for (int k = 0; k < nbytes; k++) begin
                ak = addr[7:0] + 8'(k);
                ref_mem[ak] = wdata[8*(nbytes-1-k) +: 8];
            end
            // The written word is simply the 4 bytes at addr after the update.
            exp_q.push_back(mk(0, 1, addr, ref_word(addr[7:0]), 0, m_rdata, m_err));
            exp_q.push_back(mk(0, 0, 32'h0, 32'h0, 1, 32'h0, 0));
            m_rdata = 32'h0;
            m_err   = 1'b0;
        end
    endtask

    // Per-cycle comparison against the model schedule (idle when empty).
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() != 0) cur_e = exp_q.pop_front();
            else                   cur_e = mk(1, 0, 32'h0, 32'h0, 0, m_rdata, m_err);
            check("req_ready",  32'(req_ready),  32'(cur_e.ready));
            check("data_wr",    32'(data_wr),    32'(cur_e.wr));
            check("data_addr",  data_addr,       cur_e.addr);
            check("data_out",   data_out,        cur_e.dout);
            check("resp_valid", 32'(resp_valid), 32'(cur_e.rv));
            check("resp_rdata", resp_rdata,      cur_e.rdata);
            check("resp_err",   32'(resp_err),   32'(cur_e.err));
            if (data_wr === 1'b1) begin
                obs_cnt++;
                obs_addr = data_addr;
                obs_data = data_out;
            end
        end
    end

    // Called at #1 after a rising edge; returns at #1 after the first edge
    // that starts an idle cycle.
    task automatic wait_idle();
        int guard;
        guard = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 50) begin
                check("idle_timeout", 32'(exp_q.size()), 32'h0);
                exp_q.delete();
            end
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        wait_idle();
        drive(we, size, uns, addr, wdata);
        $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h", we, size, uns, addr, wdata);
        @(posedge clk); #1;
        req_valid = 1'b0;
        model_accept(we, size, uns, addr, wdata);
    endtask

    task automatic load_pin(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                            input logic [31:0] lit);
        issue(1'b0, size, uns, addr, 32'h0);
        wait_idle();
        check("pin_load", resp_rdata, lit);
    endtask

    int cnt_before;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        n_checks = 0; n_fail = 0; obs_cnt = 0;
        obs_addr = 32'h0; obs_data = 32'h0;
        m_rdata = 32'h0; m_err = 1'b0; chk_en = 1'b0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("txn reset released");
        check("reset_ready", 32'(req_ready), 32'h1);
        check("reset_rdata", resp_rdata, 32'h0);

        // Word store, then the load variants on DE AD BE EF at 0x10
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        wait_idle();
        check("pin_sw_addr", obs_addr, 32'h10);
        check("pin_sw_data", obs_data, 32'hDEADBEEF);
        load_pin(2'b00, 1'b0, 32'h10, 32'hFFFFFFDE);
        load_pin(2'b00, 1'b1, 32'h10, 32'h000000DE);
        load_pin(2'b01, 1'b0, 32'h12, 32'hFFFFBEEF);
        load_pin(2'b01, 1'b1, 32'h12, 32'h0000BEEF);
        load_pin(2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        load_pin(2'b11, 1'b0, 32'h10, 32'hDEADBEEF);
        load_pin(2'b00, 1'b0, 32'h12, 32'hFFFFFFBE);

        // Byte store read-modify-write
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055);
        wait_idle();
        check("pin_sb_addr", obs_addr, 32'h11);
        check("pin_sb_data", obs_data, 32'h55BEEF00);
        load_pin(2'b10, 1'b0, 32'h10, 32'hDE55BEEF);

        // Reset during the WRITE cycle of a word store to 0x20
        wait_idle();
        drive(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
        $display("txn word store 0x20 with reset in WRITE");
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        exp_q.push_back(mk(0, 0, 32'h20, 32'h12345678, 0, m_rdata, m_err));
        cnt_before = obs_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        m_rdata = 32'h0;
        m_err = 1'b0;
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_mem", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'h0);
        check("rst_nowrite", 32'(obs_cnt), 32'(cnt_before));

        // Back-to-back: valid held high, second request waits for RESP
        wait_idle();
        drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        $display("txn back-to-back LW 0x10 then SH 0x22");
        @(posedge clk); #1;
        drive(1'b1, 2'b01, 1'b0, 32'h22, 32'hAAAA1234);
        model_accept(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        req_valid = 1'b0;
        model_accept(1'b1, 2'b01, 1'b0, 32'h22, 32'hAAAA1234);
        wait_idle();
        check("pin_sh_data", obs_data, 32'h12340000);
        load_pin(2'b01, 1'b0, 32'h22, 32'h00001234);
        load_pin(2'b00, 1'b1, 32'h23, 32'h00000034);

        issue(1'b1, 2'b01, 1'b0, 32'h30, 32'h00008001);
        load_pin(2'b01, 1'b0, 32'h30, 32'hFFFF8001);

        // Misaligned word load at 0x13
        issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
        wait_idle();
`ifdef LSU_MISALIGN_TRAP_EN
        check("pin_mis_err", 32'(resp_err), 32'h1);
        check("pin_mis_rdata", resp_rdata, 32'h0);
`else
        check("pin_mis_err", 32'(resp_err), 32'h0);
        check("pin_mis_rdata", resp_rdata, 32'hEF000000);
`endif
        repeat (3) @(posedge clk);
        #1;
        wait_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
